cfg_sequencer: RTL
==================

CFG_SEQUENCER -- requirements
Module: cfg_sequencer

Interface
REQ-001 Parameter STEPS, default 8: pattern table depth; power of two; step index width is log2(STEPS).
REQ-002 Parameter TEMPO_BITS, default 16: width of the tempo counter.
REQ-003 Parameter CFG_ADDR_BITS, default 3: config word address width.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 host_valid  input  1  single-cycle host byte-write strobe, already synchronized and edge-detected.
REQ-007 host_sel  input  1  0 = config register write, 1 = pattern table write.
REQ-008 host_addr  input  CFG_ADDR_BITS  config word index, or pattern entry index (low log2(STEPS) bits).
REQ-009 host_hi  input  1  byte select: 0 = bits 7:0, 1 = bits 15:8.
REQ-010 host_data  input  8  byte to write.
REQ-011 seq_run  input  1  sequencer enable level.
REQ-012 seq_last  input  log2(STEPS)  index of the last step before wrapping to step 0.
REQ-013 tempo  input  TEMPO_BITS  step period in clk cycles, minus 1.
REQ-014 cfg_we  output  2  registered config byte enables: bit0 = low byte, bit1 = high byte.
REQ-015 cfg_w_addr  output  CFG_ADDR_BITS  registered config word address.
REQ-016 cfg_w_data  output  16  registered config write data.
REQ-017 step  output  log2(STEPS)  index of the next step to play.
REQ-018 overrun  output  1  sticky flag: a pending sequencer write was lost.

Function
REQ-019 Pattern table: STEPS x 16-bit entries. Entry layout: bit15 = rest, bit14 = oscillator select, bit13 = reserved (ignored), bits12:0 = oscillator config value.
REQ-020 Host pattern write (host_valid & host_sel): updates the addressed byte of entry host_addr at the clock edge. It produces no cfg write.
REQ-021 Host config write (host_valid & ~host_sel): next cycle cfg_we = {host_hi, ~host_hi}, cfg_w_addr = host_addr, cfg_w_data = {host_data, host_data}. Latency is exactly 1 cycle.
REQ-022 Tempo counter, while seq_run = 0: held at 0; step held at 0; pending cleared; overrun cleared.
REQ-023 Tempo counter, while seq_run = 1:
- tick is asserted when the counter equals 0; on tick the counter reloads tempo.
- otherwise the counter decrements by 1.
- Consequence: first tick occurs in the first cycle seq_run is high, then every tempo+1 cycles.
REQ-024 On tick:
- entry = pattern[step].
- step becomes 0 if step == seq_last, else step+1, wrapping modulo STEPS.
- if entry bit15 = 0, the pending register loads addr = {0s, entry[14]} and data = {3'b000, entry[12:0]}, and pending is set.
- if entry bit15 = 1 (rest), pending is unchanged.
REQ-025 Pending issue: in any cycle with pending = 1 and no host config write, the output registers load cfg_we = 2'b11 with the pending addr/data, and pending clears. Tick-to-cfg_we latency is therefore 2 cycles when uncontested.
REQ-026 Arbitration: a host config write always wins the output; the pending write holds. A host pattern write does not block a pending issue.
REQ-027 Tick while pending = 1 and not issuing in the same cycle (non-rest entry): the new write replaces the pending one, and overrun sets.
REQ-028 Tick in the same cycle that pending issues: the old pending write goes out and the new one becomes pending; overrun is not set.
REQ-029 Pattern write to the entry read by a tick in the same cycle: the tick uses the old value.
REQ-030 seq_last >= STEPS cannot occur by construction. If step > seq_last (seq_last lowered mid-run), step advances and wraps at STEPS-1 -> 0.
REQ-031 tempo changes take effect at the next reload only.
REQ-032 cfg_we = 0 in every cycle where no write is issued; cfg_w_addr and cfg_w_data hold their last values.

Reset
REQ-033 On reset:
- cfg_we = 0, cfg_w_addr = 0, cfg_w_data = 0.
- step = 0, overrun = 0, pending = 0, tempo counter = 0.
- all pattern entries = 16'h8000 (rest).
REQ-034 Reset mid-operation discards any pending write; no cfg write is issued in the cycle after reset deasserts.

Verification
REQ-035 Host cfg write, addr 3, host_hi = 1, data 8'hA5 -> next cycle only: cfg_we = 2'b10, cfg_w_addr = 3, cfg_w_data = 16'hA5A5.
REQ-036 Load pattern[0] = 16'h4123, pattern[1] = 16'h8000; seq_last = 1, tempo = 3; raise seq_run at cycle T ->
- cfg_we = 11, addr 1, data 16'h0123 at T+2 and again at T+10.
- no write at T+6 (rest).
- step sequence 1, 0, 1.
REQ-037 Pending contention: host cfg writes every cycle across the T+1 issue slot -> sequencer write appears in the first cycle after host writes stop, overrun stays 0.
REQ-038 tempo = 0, host config writes continuous for 3 cycles with non-rest entries -> overrun = 1. Overrun stays 1 until seq_run is low for one cycle.
REQ-039 Assert reset while pending = 1 -> no write emerges afterward; all outputs 0; pattern entries read back as rests (no writes when rerun).

Source files
------------

// File: rtl/cfg_sequencer_if.sv
// ---------------------------------------------------------------------------
// cfg_sequencer_if
// Host byte-write bus and config write bus of the pattern sequencer.
//   host_valid  single-cycle host byte-write strobe
//   host_sel    0 = config register write, 1 = pattern table write
//   host_addr   config word index, or pattern entry index (low bits)
//   host_hi     byte select: 0 = bits 7:0, 1 = bits 15:8
//   host_data   byte to write
//   cfg_we      registered config byte enables {high, low}
//   cfg_w_addr  registered config word address
//   cfg_w_data  registered config write data
// master = host side (drives host_*), slave = sequencer side (drives cfg_*).
// ---------------------------------------------------------------------------
interface cfg_sequencer_if #(
    parameter int CFG_ADDR_BITS = 3
);
    logic                     host_valid;
    logic                     host_sel;
    logic [CFG_ADDR_BITS-1:0] host_addr;
    logic                     host_hi;
    logic [7:0]               host_data;
    logic [1:0]               cfg_we;
    logic [CFG_ADDR_BITS-1:0] cfg_w_addr;
    logic [15:0]              cfg_w_data;

    modport master (
        output host_valid, host_sel, host_addr, host_hi, host_data,
        input  cfg_we, cfg_w_addr, cfg_w_data
    );

    modport slave (
        input  host_valid, host_sel, host_addr, host_hi, host_data,
        output cfg_we, cfg_w_addr, cfg_w_data
    );
endinterface

// File: rtl/cfg_sequencer.sv
// ---------------------------------------------------------------------------
// cfg_sequencer
// Steps through a host-loaded pattern table at a programmable tempo and turns
// each non-rest entry into a 16-bit config write, sharing the config write
// port with direct host config writes (host always wins).
//   clk       sole clock, rising edge
//   reset     synchronous, active-high
//   bus       cfg_sequencer_if slave: host byte writes in, config writes out
//   seq_run   sequencer enable level
//   seq_last  index of the last step before wrapping to step 0
//   tempo     step period in clk cycles, minus 1
//   step      index of the next step to play
//   overrun   sticky: a pending sequencer write was replaced before issue
// ---------------------------------------------------------------------------
module cfg_sequencer #(
    parameter  int STEPS         = 8,
    parameter  int TEMPO_BITS    = 16,
    parameter  int CFG_ADDR_BITS = 3,
    localparam int IDX_BITS      = $clog2(STEPS)
) (
    input  logic                  clk,
    input  logic                  reset,
    cfg_sequencer_if.slave        bus,
    input  logic                  seq_run,
    input  logic [IDX_BITS-1:0]   seq_last,
    input  logic [TEMPO_BITS-1:0] tempo,
    output logic [IDX_BITS-1:0]   step,
    output logic                  overrun
);

    logic [15:0]              pattern_q [STEPS];
    logic [TEMPO_BITS-1:0]    tempo_cnt_q, tempo_cnt_d;
    logic [IDX_BITS-1:0]      step_q, step_d;
    logic                     pend_q;
    logic [CFG_ADDR_BITS-1:0] pend_addr_q;
    logic [15:0]              pend_data_q;
    logic                     overrun_q;
    logic [1:0]               cfg_we_q;
    logic [CFG_ADDR_BITS-1:0] cfg_addr_q;
    logic [15:0]              cfg_data_q;

    logic                     host_cfg;
    logic                     host_pat;
    logic                     tick;
    logic                     issue;
    logic [15:0]              entry;
    logic                     entry_unused;
    logic [IDX_BITS-1:0]      pat_idx;

    assign host_cfg     = bus.host_valid & ~bus.host_sel;
    assign host_pat     = bus.host_valid & bus.host_sel;
    assign pat_idx      = bus.host_addr[IDX_BITS-1:0];
    // The table is read from registered state, so a same-edge pattern write
    // to the entry being played cannot affect this tick.
    assign entry        = pattern_q[step_q];
    // Bit 13 of an entry is reserved.
    assign entry_unused = entry[13];
    assign tick         = seq_run && (tempo_cnt_q == '0);
    // A host config write owns the output port; the pending write waits.
    assign issue        = pend_q && !host_cfg;

    // Next step wraps at seq_last; when step is already past seq_last the
    // natural IDX_BITS overflow wraps it at STEPS-1.
    always_comb begin
        step_d = step_q + IDX_BITS'(1);
        if (step_q == seq_last) begin
            step_d = '0;
        end
        tempo_cnt_d = tick ? tempo : tempo_cnt_q - TEMPO_BITS'(1);
    end

    // Pattern table storage; reset fills every entry with a rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STEPS; i++) begin
                pattern_q[i] <= 16'h8000;
            end
        end else if (host_pat) begin
            if (bus.host_hi) begin
                pattern_q[pat_idx][15:8] <= bus.host_data;
            end else begin
                pattern_q[pat_idx][7:0] <= bus.host_data;
            end
        end
    end

    // Output port arbitration, tempo counter, step pointer and pending slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_we_q    <= '0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            tempo_cnt_q <= '0;
            step_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            if (host_cfg) begin
                cfg_we_q   <= {bus.host_hi, ~bus.host_hi};
                cfg_addr_q <= bus.host_addr;
                cfg_data_q <= {bus.host_data, bus.host_data};
            end else if (issue) begin
                cfg_we_q   <= 2'b11;
                cfg_addr_q <= pend_addr_q;
                cfg_data_q <= pend_data_q;
            end else begin
                cfg_we_q   <= '0;
            end

            if (!seq_run) begin
                tempo_cnt_q <= '0;
                step_q      <= '0;
                pend_q      <= 1'b0;
                overrun_q   <= 1'b0;
            end else begin
                tempo_cnt_q <= tempo_cnt_d;
                if (tick) begin
                    step_q <= step_d;
                end
                // A new non-rest entry always takes the slot; it only counts
                // as lost data if the old one was not leaving this cycle.
                if (tick && !entry[15]) begin
                    pend_q      <= 1'b1;
                    pend_addr_q <= {{(CFG_ADDR_BITS-1){1'b0}}, entry[14]};
                    pend_data_q <= {3'b000, entry[12:0]};
                    if (pend_q && !issue) begin
                        overrun_q <= 1'b1;
                    end
                end else if (issue) begin
                    pend_q <= 1'b0;
                end
            end
        end
    end

    assign bus.cfg_we     = cfg_we_q;
    assign bus.cfg_w_addr = cfg_addr_q;
    assign bus.cfg_w_data = cfg_data_q;
    assign step           = step_q;
    assign overrun        = overrun_q;

endmodule
